bist_sequencer: RTL
===================

# bist_sequencer

Cycle-level sequencer for the logic-BIST datapath: scan-chain circuit under test, input LFSR, output MISR. On a start request it seeds the LFSR and MISR, then runs a fixed number of scan patterns. Each pattern is a shift burst followed by one capture cycle. A final flush unloads the last response into the MISR. The sequencer then compares the MISR signature against a golden value and reports pass/fail. It sits at the BIST top level and replaces the ad-hoc `scan_en` control and the unfinished signature comparator.

## Interface

Parameters:
- `CHAIN_LEN`, default 4: scan chain length in flops; 1..255.
- `N_PATTERNS`, default 3: number of capture patterns per run; 1..65535.
- `SIG_W`, default 3: MISR signature width.
- `GOLDEN_SIG`, default 3'b101: expected fault-free signature.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `START`  in  1  BIST request, level-sampled.
- `SIG`  in  SIG_W  MISR signature, h2..h0.
- `SCAN_EN`  out  1  scan-chain shift enable; also the functional/test input mux select.
- `INIT`  out  1  one-cycle seed pulse to the LFSR and MISR.
- `LFSR_EN`  out  1  LFSR advance enable.
- `MISR_EN`  out  1  MISR compaction enable.
- `BUSY`  out  1  run in progress, INIT through COMPARE.
- `BIST_END`  out  1  run complete and result valid.
- `PASS_FAIL`  out  1  1 = signature matched, 0 = mismatch or no result.

## Operation

- States: IDLE, INIT, SHIFT, CAPTURE, FLUSH, COMPARE, DONE. The state register is cleared to IDLE by `RST`.
- All outputs except `PASS_FAIL` are Moore outputs decoded from the state register. `PASS_FAIL` is a flop.
- Output decode per state:
  - IDLE: all 0.
  - INIT: `INIT`=1, `BUSY`=1.
  - SHIFT: `SCAN_EN`=1, `LFSR_EN`=1, `MISR_EN`=1, `BUSY`=1.
  - CAPTURE: `SCAN_EN`=0, `LFSR_EN`=1, `MISR_EN`=1, `BUSY`=1.
  - FLUSH: `SCAN_EN`=1, `MISR_EN`=1, `LFSR_EN`=0, `BUSY`=1.
  - COMPARE: `BUSY`=1.
  - DONE: `BIST_END`=1.
- Transitions:
  - IDLE → INIT when `START`=1.
  - INIT → SHIFT unconditionally. Bit and pattern counters clear to 0 and `PASS_FAIL` clears to 0.
  - SHIFT → CAPTURE when bit counter = CHAIN_LEN-1; otherwise stay in SHIFT and increment the bit counter.
  - CAPTURE → SHIFT when pattern counter < N_PATTERNS-1, else → FLUSH. Increment the pattern counter and clear the bit counter.
  - FLUSH → COMPARE when bit counter = CHAIN_LEN-1; otherwise stay in FLUSH and increment the bit counter.
  - COMPARE → DONE. `PASS_FAIL` loads (`SIG` == GOLDEN_SIG) on this edge.
  - DONE → IDLE when `START`=0; stay in DONE while `START`=1, so a held `START` never retriggers.
- `START` is ignored in every state except IDLE and DONE.
- `PASS_FAIL` holds its value through DONE and IDLE and clears only on the next INIT or on `RST`.
- Counter widths: bit counter is 8 bits, pattern counter is 16 bits. Neither counter wraps within a legal run.

## Timing

- Reset value of every output is 0. Reset is asynchronous: outputs drop without waiting for a clock edge, and the state returns to IDLE from any state.
- Let `START` be sampled high at edge t0 while in IDLE.
  - INIT is active for the cycle following t0.
  - The first SHIFT cycle follows edge t0+1.
  - DONE, `BIST_END`=1 and a valid `PASS_FAIL` all appear after edge t0 + 2 + N_PATTERNS×(CHAIN_LEN+1) + CHAIN_LEN. With the default parameters this is t0+21.
- `SCAN_EN` waveform from t0+1: N_PATTERNS groups of (CHAIN_LEN high, 1 low), then CHAIN_LEN high, then low.
- `SIG` must be stable in the COMPARE cycle. It is sampled at the edge that leaves COMPARE.
- Leaving DONE: `BIST_END` falls one edge after `START` is sampled low.

## Test plan

Defaults apply: CHAIN_LEN=4, N_PATTERNS=3, GOLDEN_SIG=3'b101.

- Reset: assert `RST` asynchronously between edges → all outputs 0 immediately; IDLE after release.
- Pass run: one-cycle `START`, `SIG`=3'b101 → `INIT` is a single pulse; `SCAN_EN` pattern is 1111 0 1111 0 1111 0 1111; `BIST_END`=1 and `PASS_FAIL`=1 after t0+21.
- Fail run: `SIG`=3'b100 → `BIST_END`=1 at t0+21 and `PASS_FAIL`=0.
- Held start: `START` held high through DONE → remains in DONE with no second INIT. `START` low → IDLE next edge, `BIST_END`=0, and `PASS_FAIL` keeps its last value.
- Reset mid-run: `RST` pulse during the second SHIFT group (cycle 7) → outputs 0 at once. A new `START` then gives the full 21-cycle run and `PASS_FAIL` clears at INIT.
- Start during run: toggle `START` during SHIFT and CAPTURE → no effect, and `BIST_END` still rises at t0+21.

Source files
------------

// File: rtl/bist_sequencer.sv
// Logic-BIST run sequencer: seeds LFSR/MISR, issues shift/capture patterns,
// flushes the last response and checks the MISR signature against a golden value.
module bist_sequencer #(
  parameter int unsigned      CHAIN_LEN  = 4,
  parameter int unsigned      N_PATTERNS = 3,
  parameter int unsigned      SIG_W      = 3,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(3'b101)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [SIG_W-1:0] SIG,
  output logic             SCAN_EN,
  output logic             INIT,
  output logic             LFSR_EN,
  output logic             MISR_EN,
  output logic             BUSY,
  output logic             BIST_END,
  output logic             PASS_FAIL
);

  localparam int unsigned BIT_W = 8;
  localparam int unsigned PAT_W = 16;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(N_PATTERNS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] S_COMPARE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]       state, state_next;
  logic [BIT_W-1:0] bit_cnt, bit_next;
  logic [PAT_W-1:0] pat_cnt, pat_next;
  logic             pass_next;
  logic             scan_en_next, init_next, lfsr_en_next, misr_en_next;
  logic             busy_next, bist_end_next;

  // Next state, counter updates, and state outputs decoded from the next state
  // so the output flops track the state register exactly.
  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    pat_next   = pat_cnt;
    pass_next  = PASS_FAIL;
    case (state)
      S_IDLE: if (START) state_next = S_INIT;
      S_INIT: begin
        state_next = S_SHIFT;
        bit_next   = '0;
        pat_next   = '0;
        pass_next  = 1'b0;
      end
      S_SHIFT: begin
        if (bit_cnt == BIT_LAST) state_next = S_CAPTURE;
        else                     bit_next   = bit_cnt + BIT_W'(1);
      end
      S_CAPTURE: begin
        state_next = (pat_cnt < PAT_LAST) ? S_SHIFT : S_FLUSH;
        pat_next   = pat_cnt + PAT_W'(1);
        bit_next   = '0;
      end
      S_FLUSH: begin
        if (bit_cnt == BIT_LAST) state_next = S_COMPARE;
        else                     bit_next   = bit_cnt + BIT_W'(1);
      end
      S_COMPARE: begin
        state_next = S_DONE;
        pass_next  = (SIG == GOLDEN_SIG);
      end
      S_DONE:  if (!START) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    scan_en_next  = (state_next == S_SHIFT) || (state_next == S_FLUSH);
    init_next     = (state_next == S_INIT);
    lfsr_en_next  = (state_next == S_SHIFT) || (state_next == S_CAPTURE);
    misr_en_next  = (state_next == S_SHIFT) || (state_next == S_CAPTURE) ||
                    (state_next == S_FLUSH);
    busy_next     = (state_next != S_IDLE) && (state_next != S_DONE);
    bist_end_next = (state_next == S_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      pat_cnt   <= '0;
      PASS_FAIL <= 1'b0;
      SCAN_EN   <= 1'b0;
      INIT      <= 1'b0;
      LFSR_EN   <= 1'b0;
      MISR_EN   <= 1'b0;
      BUSY      <= 1'b0;
      BIST_END  <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_next;
      pat_cnt   <= pat_next;
      PASS_FAIL <= pass_next;
      SCAN_EN   <= scan_en_next;
      INIT      <= init_next;
      LFSR_EN   <= lfsr_en_next;
      MISR_EN   <= misr_en_next;
      BUSY      <= busy_next;
      BIST_END  <= bist_end_next;
    end
  end

endmodule
